// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the processor control path.
//   - instruction field widths and opcode values
//   - sequencer state encoding
//   - opcode-to-sequence classification helper
//   - bundled control-strobe record used by the output decode
package cpu_pkg;

    localparam int IR_W = 32;
    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    typedef enum logic [3:0] {
        S_RST  = ST_RST,
        T0     = ST_T0,
        T1     = ST_T1,
        T2     = ST_T2,
        T3     = ST_T3,
        T4     = ST_T4,
        T5     = ST_T5,
        T6     = ST_T6,
        T7     = ST_T7,
        S_HALT = ST_HALT
    } state_t;

    // Instructions grouped by the execute sequence they share.
    typedef enum logic [2:0] {
        C_ALU,   // register-register ALU op
        C_IMM,   // register-immediate ALU op
        C_LDI,
        C_LD,
        C_ST,
        C_BR,
        C_NOP,   // nop and every unassigned opcode
        C_HALT
    } op_class_t;

    typedef struct packed {
        logic read, write;
        logic pc_out, z_low_out, z_high_out, mdr_out, c_out, in_port_out, lo_out, hi_out;
        logic mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, hi_in, lo_in, c_in, in_in, out_in,
              z_in, con_in;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic alu_add, alu_sub, alu_mul, alu_div, alu_and, alu_or;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = C_ALU;
            OP_ANDI, OP_ORI:               cls = C_IMM;
            OP_LDI:                        cls = C_LDI;
            OP_LD:                         cls = C_LD;
            OP_ST:                         cls = C_ST;
            OP_BR:                         cls = C_BR;
            OP_HALT:                       cls = C_HALT;
            default:                       cls = C_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: hardwired control sequencer for the processor datapath.
// Fetches (T0-T2), decodes the opcode in T3 and steps through the execute
// states of the selected instruction, one state per clock.
//
// State table:
//   state  | meaning
//   S_RST  | held in reset, all outputs 0
//   T0     | fetch: PC to MAR, PC+1 into Z
//   T1     | fetch: Z to PC, memory read into MDR
//   T2     | fetch: MDR to IR
//   T3     | decode (opcode taken straight from ir) and first execute step
//   T4..T7 | remaining execute steps, length depends on instruction class
//   S_HALT | halted, all outputs 0, left only through clr
//
// Ports:
//   clk, clr             clock (rising edge), async active-high reset
//   ir                   instruction register from the datapath
//   con_ff               branch condition, used combinationally in br T6
//   stop                 (only with CU_STOP_EN) halt after current instruction
//   read, write          memory strobes
//   *out / *In / Gr* ... datapath bus drivers, register loads, regfile control
//   add..orSignal        ALU operation selects
//   run                  high in every state except S_RST and S_HALT
//
// Build option: define CU_STOP_EN to add the stop input.
module control_unit #(
    parameter int IR_W = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            clr,
`ifdef CU_STOP_EN
    input  logic            stop,
`endif
    input  logic [IR_W-1:0] ir,
    input  logic            con_ff,
    output logic            read,
    output logic            write,
    output logic            PCout,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            MDRout,
    output logic            Cout,
    output logic            IN_Portout,
    output logic            LOout,
    output logic            HIout,
    output logic            MARIn,
    output logic            PCIn,
    output logic            MDRIn,
    output logic            IRIn,
    output logic            YIn,
    output logic            IncPC,
    output logic            HiIn,
    output logic            LoIn,
    output logic            CIn,
    output logic            InIn,
    output logic            OutIn,
    output logic            ZIn,
    output logic            CONIn,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            RIn,
    output logic            Rout,
    output logic            BAout,
    output logic            add,
    output logic            subtract,
    output logic            multiply,
    output logic            divide,
    output logic            andSignal,
    output logic            orSignal,
    output logic            run
);
    import cpu_pkg::*;

    state_t          state, state_nxt;
    logic [OP_W-1:0] op_q, op_cur;
    op_class_t       cls;
    ctrl_t           c;
    logic            fin;
    logic            halt_req;

    // ir is only valid from T3 on (it loads at the end of T2); the opcode is
    // captured during T3 so later ir changes cannot disturb the sequence.
    assign op_cur = (state == T3) ? ir[IR_W-1 -: OP_W] : op_q;
    assign cls    = op_class(op_cur);

    logic unused_ir;
    assign unused_ir = ^ir[IR_W-OP_W-1:0];

`ifdef CU_STOP_EN
    // A stop seen during fetch is remembered so the instruction can finish.
    logic stop_pend;
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            stop_pend <= 1'b0;
        else if (fin)
            stop_pend <= 1'b0;
        else if (stop && (state == T0 || state == T1 || state == T2))
            stop_pend <= 1'b1;
    end
    assign halt_req = stop | stop_pend;
`else
    assign halt_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_RST;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == T3)
                op_q <= ir[IR_W-1 -: OP_W];
        end
    end

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        case (state)
            S_RST: state_nxt = T0;
            T0:    state_nxt = T1;
            T1:    state_nxt = T2;
            T2:    state_nxt = T3;
            T3: begin
                if (cls == C_HALT)
                    state_nxt = S_HALT;
                else if (cls == C_NOP)
                    fin = 1'b1;
                else
                    state_nxt = T4;
            end
            T4:    state_nxt = T5;
            T5: begin
                if (cls == C_LD || cls == C_ST || cls == C_BR)
                    state_nxt = T6;
                else
                    fin = 1'b1;
            end
            T6: begin
                if (cls == C_BR)
                    fin = 1'b1;
                else
                    state_nxt = T7;
            end
            T7:     fin = 1'b1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
        if (fin)
            state_nxt = halt_req ? S_HALT : T0;
    end

    always_comb begin
        c = '0;
        case (state)
            T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
            end
            T1: begin
                c.z_low_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
            end
            T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
            end
            T3: begin
                case (cls)
                    C_ALU, C_IMM: begin
                        c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
                    end
                    C_BR: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    C_ALU: begin
                        c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
                    end
                    C_IMM: begin
                        c.c_out = 1'b1; c.z_in = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        c.c_out = 1'b1; c.alu_add = 1'b1; c.z_in = 1'b1;
                    end
                    C_BR: begin
                        c.pc_out = 1'b1; c.y_in = 1'b1;
                    end
                    default: ;
                endcase
                if (cls == C_ALU || cls == C_IMM) begin
                    case (op_cur)
                        OP_ADD:          c.alu_add = 1'b1;
                        OP_SUB:          c.alu_sub = 1'b1;
                        OP_AND, OP_ANDI: c.alu_and = 1'b1;
                        OP_OR, OP_ORI:   c.alu_or  = 1'b1;
                        default: ;
                    endcase
                end
            end
            T5: begin
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin
                        c.z_low_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                    end
                    C_LD, C_ST: begin
                        c.z_low_out = 1'b1; c.mar_in = 1'b1;
                    end
                    C_BR: begin
                        c.c_out = 1'b1; c.alu_add = 1'b1; c.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (cls)
                    C_LD: begin
                        c.read = 1'b1; c.mdr_in = 1'b1;
                    end
                    C_ST: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
                    end
                    C_BR: begin
                        // Branch target sits in Z either way; only the PC load
                        // depends on the condition, so not-taken costs no cycle.
                        c.z_low_out = 1'b1; c.pc_in = con_ff;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (cls)
                    C_LD: begin
                        c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                    end
                    C_ST: c.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign run        = (state != S_RST) && (state != S_HALT);
    assign read       = c.read;
    assign write      = c.write;
    assign PCout      = c.pc_out;
    assign Zlowout    = c.z_low_out;
    assign Zhighout   = c.z_high_out;
    assign MDRout     = c.mdr_out;
    assign Cout       = c.c_out;
    assign IN_Portout = c.in_port_out;
    assign LOout      = c.lo_out;
    assign HIout      = c.hi_out;
    assign MARIn      = c.mar_in;
    assign PCIn       = c.pc_in;
    assign MDRIn      = c.mdr_in;
    assign IRIn       = c.ir_in;
    assign YIn        = c.y_in;
    assign IncPC      = c.inc_pc;
    assign HiIn       = c.hi_in;
    assign LoIn       = c.lo_in;
    assign CIn        = c.c_in;
    assign InIn       = c.in_in;
    assign OutIn      = c.out_in;
    assign ZIn        = c.z_in;
    assign CONIn      = c.con_in;
    assign Gra        = c.gra;
    assign Grb        = c.grb;
    assign Grc        = c.grc;
    assign RIn        = c.r_in;
    assign Rout       = c.r_out;
    assign BAout      = c.ba_out;
    assign add        = c.alu_add;
    assign subtract   = c.alu_sub;
    assign multiply   = c.alu_mul;
    assign divide     = c.alu_div;
    assign andSignal  = c.alu_and;
    assign orSignal   = c.alu_or;

endmodule
